// File: rtl/usart_autobaud.sv
// Autobaud detector: times the falling-edge spacing of a 0x55 sync character and derives the
// USART clock_divider (cycles per bit). Define USART_AUTOBAUD_RETRY_EN to keep hunting after a failure.
module usart_autobaud #(
  parameter int unsigned DIVIDER_WIDTH   = 12,
  parameter int unsigned COUNT_WIDTH     = 16,
  parameter int unsigned DEFAULT_DIVIDER = 64,
  parameter int unsigned MIN_DIVIDER     = 4,
  parameter int unsigned TOL_SHIFT       = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_pin,
  input  logic                     start,
  output logic [DIVIDER_WIDTH-1:0] clock_divider,
  output logic                     busy,
  output logic                     locked,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned TotalWidth = COUNT_WIDTH + 2;
  localparam int unsigned DivWidth   = TotalWidth - 3;

  typedef enum logic [2:0] {
    StIdle, StWaitHigh, StArmed, StMeasure, StStopWait, StEval, StFail
  } state_e;

  state_e                   state_q, state_d;
  logic                     sync1_q, sync2_q, prev_q;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]   ref_q, ref_d;
  logic [TotalWidth-1:0]    total_q, total_d;
  logic [2:0]               edges_q, edges_d;
  logic [DIVIDER_WIDTH-1:0] div_q, div_d;
  logic                     busy_q, busy_d;
  logic                     locked_q, locked_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;

  logic                   fall, rise, cnt_sat, div_ok;
  logic [COUNT_WIDTH-1:0] interval, deviation, tol, stop_limit;
  logic [DivWidth-1:0]    div_calc;

  assign fall       = prev_q & ~sync2_q;
  assign rise       = ~prev_q & sync2_q;
  assign cnt_sat    = &cnt_q;
  assign interval   = cnt_q + COUNT_WIDTH'(1);
  assign deviation  = (interval >= ref_q) ? (interval - ref_q) : (ref_q - interval);
  assign tol        = ref_q >> TOL_SHIFT;
  // 1.5 bit times: ref spans two bits
  assign stop_limit = (ref_q >> 1) + (ref_q >> 2);
  assign div_calc   = DivWidth'((total_q + TotalWidth'(4)) >> 3);
  assign div_ok     = (32'(div_calc) >= MIN_DIVIDER) && (32'(div_calc) < (32'd1 << DIVIDER_WIDTH));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ref_d    = ref_q;
    total_d  = total_q;
    edges_d  = edges_q;
    div_d    = div_q;
    busy_d   = busy_q;
    locked_d = locked_q;
    error_d  = error_q;
    done_d   = 1'b0;
`ifdef USART_AUTOBAUD_RETRY_EN
    error_d  = 1'b0;
`endif
    if (start) begin
      // Start overrides everything, including a result being latched this cycle
      state_d  = StWaitHigh;
      busy_d   = 1'b1;
      locked_d = 1'b0;
      error_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle:     state_d = StIdle;
        StWaitHigh: if (sync2_q) state_d = StArmed;
        StArmed: begin
          if (fall) begin
            state_d = StMeasure;
            cnt_d   = '0;
            edges_d = '0;
            total_d = '0;
          end
        end
        StMeasure: begin
          if (cnt_sat) begin
            state_d = StFail;
          end else if (fall) begin
            cnt_d   = '0;
            total_d = total_q + TotalWidth'(interval);
            edges_d = edges_q + 3'd1;
            if (edges_q == 3'd0) ref_d = interval;
            if (edges_q != 3'd0 && deviation > tol) begin
              state_d = StFail;
            end else if (edges_q == 3'd3) begin
              state_d = StStopWait;
            end
          end else begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
          end
        end
        StStopWait: begin
          if (cnt_sat || cnt_q >= stop_limit) begin
            state_d = StFail;
          end else if (rise) begin
            state_d = StEval;
          end else begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
          end
        end
        StEval: begin
          if (div_ok) begin
            div_d    = DIVIDER_WIDTH'(div_calc);
            locked_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StFail;
          end
        end
        StFail: begin
          error_d = 1'b1;
`ifdef USART_AUTOBAUD_RETRY_EN
          state_d = StWaitHigh;
`else
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= '0;
      ref_q    <= '0;
      total_q  <= '0;
      edges_q  <= '0;
      div_q    <= DIVIDER_WIDTH'(DEFAULT_DIVIDER);
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= rx_pin;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      total_q  <= total_d;
      edges_q  <= edges_d;
      div_q    <= div_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign clock_divider = div_q;
  assign busy          = busy_q;
  assign locked        = locked_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: doc/usart_autobaud.md
Name: usart_autobaud

Overview:
- Upstream companion to the USART receive/echo path.
- Measures the bit period of a sync character (0x55, 'U', 8N1, LSB first) arriving on rx_pin.
- Produces the clock_divider value, in clock cycles per bit, that feeds the USART's clock_divider input.
- Single clock domain; result held until the next measurement completes.

Parameters:
- DIVIDER_WIDTH, 12, width of the clock_divider output.
- COUNT_WIDTH, 16, width of the per-interval cycle counter; saturation means timeout.
- DEFAULT_DIVIDER, 64, clock_divider value after reset.
- MIN_DIVIDER, 4, smallest accepted result; below this, error.
- TOL_SHIFT, 2, interval tolerance: allowed deviation is first_interval >> TOL_SHIFT (25%).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_pin  in  1  raw serial line, idle high; synchronised internally.
- start  in  1  single-cycle pulse; arms a new measurement.
- clock_divider  out  DIVIDER_WIDTH  measured cycles per bit.
- busy  out  1  high while a measurement is armed or in progress.
- locked  out  1  high after a successful measurement; cleared by start.
- done  out  1  one-cycle pulse when a measurement ends, pass or fail.
- error  out  1  high after a failed measurement; cleared by start.

Behaviour:
- Reset values (asynchronous): clock_divider=DEFAULT_DIVIDER, busy=0, locked=0, done=0, error=0, state=IDLE, counters=0. The synchroniser flops reset to 1.
- rx_pin passes through a 2-flop synchroniser, then a falling/rising edge detect on the synchronised value (fixed 3-cycle lag). The lag is constant, so measured intervals are unaffected.
- IDLE: outputs hold. start -> WAIT_HIGH, busy=1, locked=0, error=0.
- WAIT_HIGH: wait until the synchronised line is high -> ARMED. Prevents arming mid-character.
- ARMED: falling edge (start bit) -> MEASURE; interval counter=0, edge count=0, total=0.
- MEASURE:
  - The interval counter increments every cycle.
  - On each falling edge: interval = counter+1; add it to total (COUNT_WIDTH+2 bits); clear counter; increment edge count.
  - For 0x55, the falling edges after the start bit fall at bit times 2, 4, 6 and 8, so each nominal interval is 2 bit times.
  - Interval 1 is stored as ref.
  - Intervals 2–4 must satisfy |interval − ref| <= ref >> TOL_SHIFT; otherwise -> FAIL.
  - After the 4th interval -> STOP_WAIT.
- STOP_WAIT:
  - The counter runs from the last falling edge.
  - A rising edge (stop bit) must arrive before counter reaches (ref>>1)+(ref>>2), i.e. 1.5 bit times; otherwise -> FAIL.
  - On the rising edge -> EVAL.
- EVAL (one cycle):
  - div = (total + 4) >> 3, i.e. total/8 rounded half-up.
  - If MIN_DIVIDER <= div < 2^DIVIDER_WIDTH: clock_divider=div, locked=1, busy=0, done=1 -> IDLE.
  - Otherwise -> FAIL.
- FAIL (one cycle): error=1, busy=0, done=1, clock_divider unchanged -> IDLE.
- Timeout: the interval counter saturates at all-ones in MEASURE or STOP_WAIT -> FAIL. It never wraps.
- start while busy: aborts and restarts at WAIT_HIGH. No done pulse for the aborted measurement.
- start in the same cycle as EVAL/FAIL: start wins; no result is latched, and no done pulse is issued.
- Reset mid-measurement: all state returns immediately to the reset values.
- Latency: done asserts 2 cycles after the synchronised stop-bit rising edge is detected (EVAL cycle, then the registered output).

Optional Feature:
- Macro: USART_AUTOBAUD_RETRY_EN.
- When defined: FAIL re-enters WAIT_HIGH instead of IDLE. busy stays 1, error pulses high for one cycle, and done does not assert on failure. The block keeps hunting until success or reset.
- When undefined: behaviour as above; error is sticky until the next start.

Test Plan:
- 0x55 at 64 cycles/bit after start -> intervals 128 each, total 512, clock_divider=64, locked=1, done pulse, error=0.
- 0x55 at 104 cycles/bit -> total 832, clock_divider=104.
- 0x55 with intervals 25,25,26,25 cycles -> total 101, clock_divider=(101+4)>>3=13.
- 0x7F sent at 64 cycles/bit (single low data-bit run breaks the interval pattern) -> error=1, locked=0, clock_divider stays 64.
- Line held low after the start bit -> counter saturates -> error=1. With USART_AUTOBAUD_RETRY_EN, busy stays 1, and a following valid 0x55 at 64 cycles/bit yields locked=1 with clock_divider=64.
- Reset asserted mid-MEASURE -> clock_divider=64, busy=0, locked=0, error=0 immediately; a start pulse mid-MEASURE restarts cleanly with no done pulse.
